das_trace_capture: RTL and testbench

Trace capture stage sitting directly downstream of the 200 MHz ADC sample source (`adc_200mhz_gen` in simulation, the real ADC interface in hardware). On each probe-pulse trigger it waits a programmable delay, then captures a programmable number of consecutive 14-bit samples. Each sample is converted to sign-extended two's complement, and the samples are streamed out through a small FIFO with valid/ready/last handshake. It forms the entry point of the DAS trace-processing chain.

---
 rtl/das_pkg.sv | 35 +++
 rtl/das_sync_fifo.sv | 68 ++++++
 rtl/das_trace_capture.sv | 127 ++++++++++++
 tb/tb_das_trace_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/das_pkg.sv
`default_nettype none
// ============================================================================
// Module      : das_pkg
// Description : Shared widths, FSM state encoding and the ADC sample
//               conversion helper for the DAS trace-processing chain.
// Contents    : ADC_W, SAMPLE_W, CNT_W, trace_state_t, adc_to_sample()
// Revision    : 1.0 - initial release
// ============================================================================
package das_pkg;

  localparam int ADC_W    = 14;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 16;

  // Explicitly encoded so the state value is stable across tools and readable
  // in a waveform.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2
  } trace_state_t;

  // Offset-binary input has its MSB inverted to become two's complement;
  // the result is then sign-extended to the stream width.
  function automatic logic [SAMPLE_W-1:0] adc_to_sample(
    input logic [ADC_W-1:0] raw,
    input logic             offset_binary
  );
    logic [ADC_W-1:0] x;
    x = offset_binary ? {~raw[ADC_W-1], raw[ADC_W-2:0]} : raw;
    return {{(SAMPLE_W-ADC_W){x[ADC_W-1]}}, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/das_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : das_sync_fifo
// Description : Single-clock FIFO with a show-ahead read port. The head entry
//               is presented from registered storage whenever the FIFO is not
//               empty, and reads as zero when empty.
// Ports       : clk, rst (sync, active high)
//               wr_en/wr_data  - write request (ignored when full unless the
//                                same cycle also pops an entry)
//               rd_en          - pop the head entry (ignored when empty)
//               rd_data        - head entry
//               full, empty    - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module das_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // Fullness is judged before the pop, so a full FIFO accepts a write only
  // when an entry leaves in the same cycle.
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/das_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : das_trace_capture
// Description : Triggered ADC trace capture. A trigger rising edge starts a
//               programmable delay followed by a programmable number of
//               consecutive samples; samples are converted to sign-extended
//               two's complement and streamed out through a FIFO.
// Ports       : clk_i, reset_i (sync, active high)
//               adc_data_i     - 14-bit ADC sample, one per cycle
//               trig_i         - probe-pulse trigger (rising edge)
//               delay_i        - samples skipped after trigger
//               length_i       - samples per trace (0 = no capture)
//               m_data_o/m_last_o/m_valid_o/m_ready_i - output stream
//               busy_o         - trace in progress (delay or capture)
//               overflow_o     - sticky: a sample of this/last trace dropped
// Revision    : 1.0 - initial release
// ============================================================================
module das_trace_capture
  import das_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADC_W-1:0]    adc_data_i,
  input  logic                trig_i,
  input  logic [CNT_W-1:0]    delay_i,
  input  logic [CNT_W-1:0]    length_i,
  output logic [SAMPLE_W-1:0] m_data_o,
  output logic                m_last_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                overflow_o
);

  trace_state_t        state;
  logic                trig_d;
  logic                trig_ev;
  logic                start;
  logic [CNT_W-1:0]    delay_cnt;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    idx;
  logic                idx_is_last;
  logic [SAMPLE_W-1:0] s1_data;
  logic                s1_valid;
  logic                s1_last;
  logic                overflow_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;
  logic [SAMPLE_W:0]   fifo_rd;

  assign trig_ev     = trig_i & ~trig_d;
  assign start       = trig_ev & (state == ST_IDLE) & (length_i != '0);
  assign idx_is_last = (idx == len_q - CNT_W'(1));
  // A full FIFO always has a head entry, so only ready decides whether the
  // incoming sample finds room.
  assign drop        = s1_valid & fifo_full & ~m_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      trig_d     <= 1'b0;
      state      <= ST_IDLE;
      delay_cnt  <= '0;
      len_q      <= '0;
      idx        <= '0;
      s1_data    <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      trig_d   <= trig_i;
      // The write flag travels with the converted sample so the FIFO write
      // lands one cycle after the sample is taken.
      s1_data  <= adc_to_sample(adc_data_i, OFFSET_BINARY);
      s1_valid <= (state == ST_CAPTURE);
      s1_last  <= (state == ST_CAPTURE) & idx_is_last;
      // A drop in the same cycle as a new trigger belongs to the previous
      // trace and is still reported.
      overflow_q <= (overflow_q & ~start) | drop;

      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= length_i;
            delay_cnt <= delay_i;
            idx       <= '0;
            state     <= (delay_i != '0) ? ST_DELAY : ST_CAPTURE;
          end
        end
        ST_DELAY: begin
          delay_cnt <= delay_cnt - CNT_W'(1);
          if (delay_cnt == CNT_W'(1)) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          idx <= idx + CNT_W'(1);
          if (idx_is_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  das_sync_fifo #(
    .WIDTH (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (reset_i),
    .wr_en   (s1_valid),
    .wr_data ({s1_last, s1_data}),
    .rd_en   (m_ready_i),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_data_o   = fifo_rd[SAMPLE_W-1:0];
  assign m_last_o   = fifo_rd[SAMPLE_W];
  assign m_valid_o  = ~fifo_empty;
  assign busy_o     = (state != ST_IDLE);
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_das_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_das_trace_capture
// Description : Self-checking bench for das_trace_capture. A time-window
//               model of the trace schedule and a queue model of the output
//               FIFO are compared against the DUT every cycle; directed
//               scenarios add hand-computed expectations on captured beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_das_trace_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig;
  logic        ready;
  logic [13:0] adc;
  logic [15:0] dly;
  logic [15:0] len;

  logic [15:0] m_data,  m_data2;
  logic        m_last,  m_last2;
  logic        m_valid, m_valid2;
  logic        busy,    busy2;
  logic        ovf,     ovf2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  das_trace_capture #(.FIFO_DEPTH(DEPTH), .OFFSET_BINARY(1'b1)) dut (
    .clk_i(clk), .reset_i(reset), .adc_data_i(adc), .trig_i(trig),
    .delay_i(dly), .length_i(len), .m_data_o(m_data), .m_last_o(m_last),
    .m_valid_o(m_valid), .m_ready_i(ready), .busy_o(busy), .overflow_o(ovf)
  );

  das_trace_capture #(.FIFO_DEPTH(DEPTH), .OFFSET_BINARY(1'b0)) dut_tc (
    .clk_i(clk), .reset_i(reset), .adc_data_i(adc), .trig_i(trig),
    .delay_i(dly), .length_i(len), .m_data_o(m_data2), .m_last_o(m_last2),
    .m_valid_o(m_valid2), .m_ready_i(ready), .busy_o(busy2), .overflow_o(ovf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Sample value as a signed number, reduced to 16 bits.
  function automatic logic [15:0] conv(input logic [13:0] raw, input bit ob);
    int v;
    v = int'(raw);
    if (ob) v = v - 8192;
    else if (v >= 8192) v = v - 16384;
    return v[15:0];
  endfunction

  // ---------------- model ----------------
  // A trace accepted at edge t0 with delay md and length ml takes sample k
  // at edge t0+1+md+k; each sample enters the FIFO one edge later.
  logic [16:0] mq[$];
  logic [16:0] rx[$];
  logic [16:0] rx2[$];
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_trig_d = 0;
  bit          m_ovf = 0;
  bit          wr_pend = 0;
  logic [16:0] wr_beat = '0;
  int          t0 = 0, md = 0, ml = 0;
  bit          ev, rd, full, drop, start, np;
  logic [16:0] nb;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_active = 0;
      m_trig_d = 0;
      m_ovf    = 0;
      wr_pend  = 0;
    end else begin
      ev       = trig && !m_trig_d;
      m_trig_d = trig;
      full     = (mq.size() == DEPTH);
      rd       = (mq.size() != 0) && ready;
      if (rd) void'(mq.pop_front());
      drop = 0;
      if (wr_pend) begin
        if (!full || rd) mq.push_back(wr_beat);
        else drop = 1;
      end
      np    = m_active && (cyc >= t0 + 1 + md) && (cyc <= t0 + md + ml);
      nb    = {(cyc == t0 + md + ml), conv(adc, 1'b1)};
      start = ev && (len != 0) && !(m_active && cyc >= t0 + 1 && cyc <= t0 + md + ml);
      if (start) begin
        m_active = 1;
        t0 = cyc;
        md = int'(dly);
        ml = int'(len);
      end
      m_ovf   = (m_ovf && !start) || drop;
      wr_pend = np;
      wr_beat = nb;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en   = 0;
  int busy_cnt = 0;
  int e;
  bit exp_busy;

  always @(negedge clk) begin
    if (chk_en) begin
      e        = cyc - 1;
      exp_busy = m_active && (e >= t0) && (e <= t0 + md + ml - 1);
      check("valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("data", m_data, mq[0][15:0]);
        check("last", m_last, mq[0][16]);
      end
      check("busy", busy, exp_busy);
      check("overflow", ovf, m_ovf);
      if (busy) busy_cnt++;
      if (m_valid && ready) rx.push_back({m_last, m_data});
      if (m_valid2 && ready) rx2.push_back({m_last2, m_data2});
    end
  end

  // ---------------- stimulus ----------------
  bit ramp = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp) adc = adc + 14'd1;
  endtask

  task automatic trigger(input logic [15:0] d, input logic [15:0] l);
    dly  = d;
    len  = l;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  int lasts;

  initial begin
    reset = 1'b1; trig = 1'b0; ready = 1'b1; adc = '0; dly = '0; len = '0;
    tick();
    chk_en = 1;
    tick(); tick();
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 16'h0000);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;
    tick();

    // Ramp capture, no delay
    rx.delete(); adc = 14'h1FFF; ramp = 1;
    trigger(16'd0, 16'd4);
    repeat (8) tick();
    check("ramp_count", rx.size(), 4);
    if (rx.size() == 4) begin
      check("ramp_b0", rx[0], 17'h00000);
      check("ramp_b1", rx[1], 17'h00001);
      check("ramp_b2", rx[2], 17'h00002);
      check("ramp_b3", rx[3], 17'h10003);
    end
    check("ramp_ovf", ovf, 0);

    // Delay of 3, length 2
    rx.delete(); busy_cnt = 0; adc = 14'h1FFF;
    trigger(16'd3, 16'd2);
    repeat (9) tick();
    check("delay_count", rx.size(), 2);
    if (rx.size() == 2) begin
      check("delay_b0", rx[0], 17'h00003);
      check("delay_b1", rx[1], 17'h10004);
    end
    check("delay_busy_cycles", busy_cnt, 5);

    // Conversion, both input formats
    rx.delete(); rx2.delete(); ramp = 0;
    trigger(16'd0, 16'd3);
    adc = 14'h0000; tick();
    adc = 14'h3FFF; tick();
    adc = 14'h2000; tick();
    repeat (6) tick();
    check("conv_count", rx.size(), 3);
    if (rx.size() == 3) begin
      check("conv_0000", rx[0], 17'h0E000);
      check("conv_3fff", rx[1], 17'h01FFF);
      check("conv_2000", rx[2], 17'h10000);
    end
    check("conv_tc_count", rx2.size(), 3);
    if (rx2.size() == 3) begin
      check("conv_tc_0000", rx2[0], 17'h00000);
      check("conv_tc_3fff", rx2[1], 17'h0FFFF);
      check("conv_tc_2000", rx2[2], 17'h1E000);
    end

    // Overflow with a stalled sink
    rx.delete(); busy_cnt = 0; ready = 0; adc = 14'h1FFF; ramp = 1;
    trigger(16'd0, 16'd20);
    repeat (24) tick();
    check("ovf_set", ovf, 1);
    check("ovf_busy_cycles", busy_cnt, 20);
    check("ovf_busy_low", busy, 0);
    check("ovf_valid", m_valid, 1);
    ready = 1;
    repeat (20) tick();
    check("ovf_beats", rx.size(), DEPTH);
    if (rx.size() == DEPTH) begin
      check("ovf_first", rx[0], 17'h00000);
      check("ovf_16th", rx[DEPTH-1], 17'h0000F);
    end
    lasts = 0;
    foreach (rx[i]) if (rx[i][16]) lasts++;
    check("ovf_no_last", lasts, 0);
    check("ovf_sticky", ovf, 1);
    trigger(16'd0, 16'd1);
    check("ovf_cleared", ovf, 0);
    repeat (5) tick();

    // Trigger during capture is ignored
    rx.delete(); adc = 14'h1FFF;
    trigger(16'd0, 16'd6);
    tick(); tick();
    trigger(16'd5, 16'd3);
    repeat (12) tick();
    check("ign_count", rx.size(), 6);
    if (rx.size() == 6) check("ign_last", rx[5], 17'h10005);

    // A held trigger level produces one trace
    rx.delete(); dly = 16'd0; len = 16'd2; trig = 1'b1;
    repeat (8) tick();
    trig = 1'b0;
    repeat (4) tick();
    check("held_count", rx.size(), 2);

    // Zero length is ignored entirely
    rx.delete(); busy_cnt = 0;
    trigger(16'd3, 16'd0);
    repeat (8) tick();
    check("zero_len_beats", rx.size(), 0);
    check("zero_len_busy", busy_cnt, 0);

    // Reset in the middle of a capture
    adc = 14'h1FFF;
    trigger(16'd0, 16'd10);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("rstmid_valid", m_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_data", m_data, 16'h0000);
    reset = 1'b0;
    tick();
    rx.delete(); adc = 14'h1FFF;
    trigger(16'd0, 16'd10);
    repeat (14) tick();
    check("rstmid_count", rx.size(), 10);
    if (rx.size() == 10) begin
      check("rstmid_first", rx[0], 17'h00000);
      check("rstmid_last", rx[9], 17'h10009);
    end
    lasts = 0;
    foreach (rx[i]) if (rx[i][16]) lasts++;
    check("rstmid_one_last", lasts, 1);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
